// File: rtl/ccc_lock_pkg.sv
// rtl/ccc_lock_pkg.sv - State type and counter-width helpers for ccc_lock_reset_ctrl
package ccc_lock_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } lock_state_t;

  localparam int SYNC_STAGES = 2;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - Two-flop synchronizer for asynchronous CCC status inputs, reset to 0
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ccc_lock_reset_ctrl.sv
// rtl/ccc_lock_reset_ctrl.sv - Fabric reset/heartbeat controller behind the CCC; LOCK_LOSS_COUNT_EN adds the loss counter
module ccc_lock_reset_ctrl
  import ccc_lock_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int BLINK_CYCLES  = 25_000_000,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic GL0,
  input  logic POWER_ON_RESET_N,
  input  logic LOCK,
  output logic FAB_RESET_N_OUT,
  output logic READY,
  output logic LED
`ifdef LOCK_LOSS_COUNT_EN
  ,
  input  logic                  LOSS_CLR,
  output logic [LOSS_CNT_W-1:0] LOSS_COUNT
`endif
);

  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int BW = cnt_w(BLINK_CYCLES);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);

  lock_state_t   state_q, state_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          led_q, led_d;
  logic          lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i  (GL0),
    .rst_ni (POWER_ON_RESET_N),
    .d_i    (LOCK),
    .q_o    (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    hold_d   = '0;
    blink_d  = '0;
    led_d    = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        stable_d = '0;
        if (lock_s) begin
          // The cycle that leaves WAIT_LOCK is itself the first qualifying cycle.
          if (STABLE_CYCLES == 1) begin
            state_d = RUN;
          end else begin
            state_d  = STABLE;
            stable_d = SW'(1);
          end
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          stable_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          state_d  = RUN;
          stable_d = '0;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = HOLD;
        end else begin
          led_d = led_q;
          if (blink_q == BLINK_LAST) begin
            led_d = ~led_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge GL0 or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      state_q  <= WAIT_LOCK;
      stable_q <= '0;
      hold_q   <= '0;
      blink_q  <= '0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      hold_q   <= hold_d;
      blink_q  <= blink_d;
      led_q    <= led_d;
    end
  end

  assign FAB_RESET_N_OUT = (state_q == RUN);
  assign READY           = (state_q == RUN);
  assign LED             = led_q;

`ifdef LOCK_LOSS_COUNT_EN
  logic                  loss_evt;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  assign loss_evt = (state_q == RUN) && !lock_s;

  // A clear coinciding with a loss keeps that loss rather than dropping it.
  always_comb begin
    loss_d = loss_q;
    if (LOSS_CLR) begin
      loss_d = loss_evt ? LOSS_CNT_W'(1) : '0;
    end else if (loss_evt && !(&loss_q)) begin
      loss_d = loss_q + 1'b1;
    end
  end

  always_ff @(posedge GL0 or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign LOSS_COUNT = loss_q;
`endif

endmodule

// File: tb/tb_ccc_lock_reset_ctrl.sv
// tb/tb_ccc_lock_reset_ctrl.sv - Scoreboard bench for ccc_lock_reset_ctrl against a cycle-count reference model
`timescale 1ns/1ps
module tb_ccc_lock_reset_ctrl;

  localparam int S  = 8;
  localparam int H  = 4;
  localparam int B  = 5;
  localparam int LW = 2;

  logic GL0 = 1'b0;
  logic POWER_ON_RESET_N;
  logic LOCK;
  logic FAB_RESET_N_OUT;
  logic READY;
  logic LED;
`ifdef LOCK_LOSS_COUNT_EN
  logic          LOSS_CLR;
  logic [LW-1:0] LOSS_COUNT;
`endif

  always #5 GL0 = ~GL0;

  ccc_lock_reset_ctrl #(
    .STABLE_CYCLES (S),
    .HOLD_CYCLES   (H),
    .BLINK_CYCLES  (B),
    .LOSS_CNT_W    (LW)
  ) dut (
    .GL0              (GL0),
    .POWER_ON_RESET_N (POWER_ON_RESET_N),
    .LOCK             (LOCK),
    .FAB_RESET_N_OUT  (FAB_RESET_N_OUT),
    .READY            (READY),
    .LED              (LED)
`ifdef LOCK_LOSS_COUNT_EN
    ,
    .LOSS_CLR         (LOSS_CLR),
    .LOSS_COUNT       (LOSS_COUNT)
`endif
  );

  typedef struct {
    int       edge_no;
    logic     run;
    logic     led;
    logic [LW-1:0] loss;
  } exp_t;

  exp_t sb_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   edge_cnt   = 0;
  logic drv_rst    = 1'b0;

  // Reference model: lock is seen two samples late; release after S consecutive
  // high samples; a loss holds reset for H edges before qualification restarts.
  bit m_s1, m_s2, m_run, m_led;
  int m_streak, m_hold, m_phase, m_loss;

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_run = 0; m_led = 0;
    m_streak = 0; m_hold = 0; m_phase = 0; m_loss = 0;
  endfunction

  function automatic void model_edge(input bit lock, input bit clr, input bit rst_n);
    bit ls;
    bit loss;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = lock;
    loss = 0;
    if (m_hold > 0) begin
      m_hold--;
    end else if (m_run) begin
      if (!ls) begin
        m_run = 0; m_hold = H; m_led = 0; m_phase = 0; loss = 1;
      end else begin
        m_phase++;
        if (m_phase == B) begin
          m_phase = 0;
          m_led = !m_led;
        end
      end
    end else if (ls) begin
      m_streak++;
      if (m_streak == S) begin
        m_run = 1; m_streak = 0; m_phase = 0;
      end
    end else begin
      m_streak = 0;
    end
`ifdef LOCK_LOSS_COUNT_EN
    if (clr) m_loss = loss ? 1 : 0;
    else if (loss && m_loss < (1 << LW) - 1) m_loss++;
`endif
  endfunction

  task automatic step(input bit lock, input bit clr);
    exp_t e;
    @(posedge GL0);
    #7;
    POWER_ON_RESET_N = drv_rst;
    LOCK = lock;
`ifdef LOCK_LOSS_COUNT_EN
    LOSS_CLR = clr;
`endif
    model_edge(lock, clr, drv_rst);
    edge_cnt++;
    e.edge_no = edge_cnt;
    e.run     = m_run;
    e.led     = m_led;
    e.loss    = LW'(m_loss);
    sb_q.push_back(e);
  endtask

  task automatic run_high(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic loss_event(input bit clr_on_loss);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, clr_on_loss);
    run_high(H + S + 2);
  endtask

  initial begin : monitor
    exp_t e;
    bit   bad;
    forever begin
      @(negedge GL0);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        bad = (FAB_RESET_N_OUT !== e.run) || (READY !== e.run) || (LED !== e.led);
`ifdef LOCK_LOSS_COUNT_EN
        bad = bad || (LOSS_COUNT !== e.loss);
        if (bad) $display("FAIL edge%0d: fab=%b ready=%b led=%b loss=%0d, expected fab=%b ready=%b led=%b loss=%0d",
                          e.edge_no, FAB_RESET_N_OUT, READY, LED, LOSS_COUNT, e.run, e.run, e.led, e.loss);
`else
        if (bad) $display("FAIL edge%0d: fab=%b ready=%b led=%b, expected fab=%b ready=%b led=%b",
                          e.edge_no, FAB_RESET_N_OUT, READY, LED, e.run, e.run, e.led);
`endif
        if (bad) miscompares++;
      end
    end
  end

  initial begin : stimulus
    int n;
    POWER_ON_RESET_N = 1'b0;
    LOCK = 1'b1;
`ifdef LOCK_LOSS_COUNT_EN
    LOSS_CLR = 1'b0;
`endif
    model_reset();

    // Held in reset with LOCK high: outputs stay at reset values.
    drv_rst = 1'b0;
    run_high(4);
    drv_rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // Glitch: 5 high, 2 low, then a clean rise that must release after m+9.
    run_high(5);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_high(S + 14);

    // Loss with fast return, then saturation over several more losses.
    loss_event(1'b0);
    for (int i = 0; i < 5; i++) loss_event(1'b0);

    // Plain clear, then build to 2 and clear on the loss edge itself.
    step(1'b1, 1'b1);
    run_high(3);
    loss_event(1'b0);
    loss_event(1'b0);
    loss_event(1'b1);

    // Asynchronous reset in RUN while LED is lit.
    n = 0;
    while (!(m_run && m_led) && n < 60) begin
      step(1'b1, 1'b0);
      n++;
    end
    @(posedge GL0);
    #7;
    vectors++;
    if (FAB_RESET_N_OUT !== 1'b1 || LED !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_async_reset: fab=%b led=%b, expected fab=1 led=1", FAB_RESET_N_OUT, LED);
    end
    POWER_ON_RESET_N = 1'b0;
    drv_rst = 1'b0;
    #1;
    vectors++;
    if (FAB_RESET_N_OUT !== 1'b0 || READY !== 1'b0 || LED !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: fab=%b ready=%b led=%b, expected 0 0 0", FAB_RESET_N_OUT, READY, LED);
    end
`ifdef LOCK_LOSS_COUNT_EN
    vectors++;
    if (LOSS_COUNT !== '0) begin
      miscompares++;
      $display("FAIL async_reset_loss: loss=%0d, expected 0", LOSS_COUNT);
    end
`endif
    model_reset();
    run_high(3);
    drv_rst = 1'b1;

    // Random segments of lock high/low with sporadic clears.
    for (int seg = 0; seg < 120; seg++) begin
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) step(1'b1, ($urandom_range(0, 15) == 0));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) step(1'b0, ($urandom_range(0, 15) == 0));
    end

    repeat (3) @(posedge GL0);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
